imem_loader: RTL and testbench

Hardware program loader: the write side of the core's instruction memory. It accepts a framed byte stream over a valid/ready interface, for example from a UART receiver, and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory from word address 0, verifies a trailing XOR checksum, and holds the core in reset until a load completes successfully. It sits between the host link and `core_top`, taking over the role that `$readmemh` fills in simulation.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_packer.sv | 49 ++++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Byte-to-word assembler: collects four stream bytes little-endian into
// lane registers, flags the cycle after a word completes, and keeps a
// running XOR of every byte it has accepted since the last clear.
module imem_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic        o_lastByte,
  output logic        o_wordFull,
  output logic [31:0] o_word,
  output logic [7:0]  o_checksum
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]      r_byteIdx;
  logic [3:0][7:0] r_lanes;
  logic            r_wordFull;
  logic [7:0]      r_checksum;

  assign o_lastByte = (r_byteIdx == LAST_LANE);
  assign o_wordFull = r_wordFull;
  assign o_word     = r_lanes;
  assign o_checksum = r_checksum;

  // Place each accepted byte in its lane, fold it into the checksum, and
  // raise the word-complete flag for one cycle after the top lane fills.
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_byteIdx  <= 2'd0;
      r_lanes    <= '0;
      r_wordFull <= 1'b0;
      r_checksum <= 8'd0;
    end else begin
      r_wordFull <= 1'b0;
      if (i_en) begin
        r_lanes[r_byteIdx] <= i_data;
        r_checksum         <= r_checksum ^ i_data;
        r_byteIdx          <= r_byteIdx + 2'd1;
        r_wordFull         <= (r_byteIdx == LAST_LANE);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed, XOR-checksummed byte frame,
// writes the words into instruction memory from address 0 and releases
// the core from reset only after a fully verified load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Capacity in words; one bit wider than the 16-bit length so that a
  // 16-bit address space can still be compared against.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  loader_state_t         r_state;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rxReady;
  logic                  r_coreHold;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic        w_handshake;
  logic        w_startLoad;
  logic        w_packEn;
  logic        w_lastByte;
  logic        w_wordFull;
  logic [31:0] w_word;
  logic [7:0]  w_checksum;
  logic [16:0] w_lenFull;
  logic        w_lenBad;
  logic        w_lastWord;

  assign w_handshake = rx_valid && r_rxReady;
  assign w_startLoad = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_packEn    = w_handshake && (r_state == DATA);
  assign w_lenFull   = {1'b0, rx_data, r_len[7:0]};
  assign w_lenBad    = (w_lenFull == 17'd0) || (w_lenFull > CAPACITY);
  assign w_lastWord  = (17'(r_addr) + 17'd1) == {1'b0, r_len};

  assign rx_ready  = r_rxReady;
  assign mem_we    = w_wordFull;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_word;
  assign core_hold = r_coreHold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_startLoad),
    .i_en       (w_packEn),
    .i_data     (rx_data),
    .o_lastByte (w_lastByte),
    .o_wordFull (w_wordFull),
    .o_word     (w_word),
    .o_checksum (w_checksum)
  );

  // Frame sequencer: walks length, data/write and checksum phases and
  // registers every status output alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_len      <= 16'd0;
      r_addr     <= '0;
      r_rxReady  <= 1'b0;
      r_coreHold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= LEN_LO;
            r_len      <= 16'd0;
            r_addr     <= '0;
            r_rxReady  <= 1'b1;
            r_coreHold <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        LEN_LO: begin
          if (w_handshake) begin
            r_len[7:0] <= rx_data;
            r_state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (w_handshake) begin
            r_len[15:8] <= rx_data;
            if (w_lenBad) begin
              r_state   <= ERR;
              r_rxReady <= 1'b0;
              r_busy    <= 1'b0;
              r_error   <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_handshake && w_lastByte) begin
            r_state   <= WRITE;
            r_rxReady <= 1'b0;
          end
        end
        WRITE: begin
          r_addr    <= r_addr + ADDR_WIDTH'(1);
          r_rxReady <= 1'b1;
          r_state   <= w_lastWord ? CSUM : DATA;
        end
        CSUM: begin
          if (w_handshake) begin
            r_rxReady <= 1'b0;
            r_busy    <= 1'b0;
            if (rx_data == w_checksum) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_coreHold <= 1'b0;
            end else begin
              r_state <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists,
// and expected memory contents, outcome and timing come from the frame
// rules themselves.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  int tests  = 0;
  int failed = 0;
  int cycle  = 0;
  int weWhileReady = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t wrLog[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Record every memory write seen by the instruction memory
  always @(negedge clk) begin
    if (mem_we) begin
      wrLog.push_back('{mem_addr, mem_wdata});
      if (rx_ready) weWhileReady++;
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      failed++;
      $display("[TB] FAIL handshake_timeout: rx_ready=%0b required 1 within 100 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] words[$], input logic [15:0] n,
                            input bit badCsum, input int minGap, input int maxGap,
                            input int midStartWord);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'd0;
    send_byte(n[7:0], $urandom_range(maxGap, minGap));
    send_byte(n[15:8], $urandom_range(maxGap, minGap));
    for (int w = 0; w < words.size(); w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[w][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, $urandom_range(maxGap, minGap));
      end
      if (w == midStartWord) pulse_start();
    end
    send_byte(badCsum ? (cs ^ 8'h01) : cs, $urandom_range(maxGap, minGap));
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({core_hold, rx_ready, mem_we, busy, done, error} !== 6'b100000) begin
      failed++;
      $display("[TB] FAIL reset_status: got %b required 100000",
               {core_hold, rx_ready, mem_we, busy, done, error});
    end
    tests++;
    if ({mem_addr, mem_wdata} !== 40'd0) begin
      failed++;
      $display("[TB] FAIL reset_bus: got addr %0h data %0h required 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({core_hold, rx_ready, busy} !== 3'b100) begin
      failed++;
      $display("[TB] FAIL idle_after_reset: got %b required 100", {core_hold, rx_ready, busy});
    end
  endtask

  task automatic test_single_word;
    logic [31:0] w[$];
    int c0;
    w = {32'h00500093};
    wrLog.delete();
    pulse_start();
    c0 = cycle;
    tests++;
    if ({rx_ready, busy, core_hold} !== 3'b111) begin
      failed++;
      $display("[TB] FAIL single_started: got %b required 111", {rx_ready, busy, core_hold});
    end
    send_frame(w, 16'd1, 1'b0, 0, 0, -1);
    tests++;
    if ({done, error, core_hold, busy} !== 4'b1000) begin
      failed++;
      $display("[TB] FAIL single_status: got %b required 1000", {done, error, core_hold, busy});
    end
    tests++;
    if (wrLog.size() != 1 || wrLog[0].addr !== 8'd0 || wrLog[0].data !== 32'h00500093) begin
      failed++;
      $display("[TB] FAIL single_write: got %0d writes first %0h required 1 write 0:00500093",
               wrLog.size(), (wrLog.size() > 0) ? wrLog[0].data : 32'hx);
    end
    tests++;
    if (cycle - c0 != 8) begin
      failed++;
      $display("[TB] FAIL single_latency: got %0d cycles required 8", cycle - c0);
    end
  endtask

  task automatic test_bad_checksum;
    logic [31:0] w[$];
    w = {32'h00500093};
    wrLog.delete();
    pulse_start();
    send_frame(w, 16'd1, 1'b1, 0, 1, -1);
    tests++;
    if ({done, error, core_hold, busy} !== 4'b0110) begin
      failed++;
      $display("[TB] FAIL badcsum_status: got %b required 0110", {done, error, core_hold, busy});
    end
    pulse_start();
    tests++;
    if ({done, error, busy} !== 3'b001) begin
      failed++;
      $display("[TB] FAIL restart_clears: got %b required 001", {done, error, busy});
    end
    send_frame(w, 16'd1, 1'b0, 0, 1, -1);
    tests++;
    if ({done, error, core_hold} !== 3'b100) begin
      failed++;
      $display("[TB] FAIL reload_status: got %b required 100", {done, error, core_hold});
    end
  endtask

  task automatic test_bad_length;
    logic [15:0] lens[2];
    lens[0] = 16'd0;
    lens[1] = 16'd257;
    foreach (lens[i]) begin
      wrLog.delete();
      pulse_start();
      send_byte(lens[i][7:0], 0);
      send_byte(lens[i][15:8], 0);
      tests++;
      if ({error, done, core_hold, busy, rx_ready} !== 5'b10100) begin
        failed++;
        $display("[TB] FAIL badlen_%0d_status: got %b required 10100", lens[i],
                 {error, done, core_hold, busy, rx_ready});
      end
      repeat (3) @(negedge clk);
      tests++;
      if (wrLog.size() != 0) begin
        failed++;
        $display("[TB] FAIL badlen_%0d_writes: got %0d required 0", lens[i], wrLog.size());
      end
    end
  endtask

  task automatic test_sum_program;
    logic [31:0] w[$];
    w = {32'h00000093, 32'h00500113, 32'h002080B3, 32'hFFF10113,
         32'hFE011CE3, 32'h0000006F, 32'h00000013};
    wrLog.delete();
    weWhileReady = 0;
    pulse_start();
    send_frame(w, 16'd7, 1'b0, 1, 1, 3);
    tests++;
    if ({done, error, core_hold} !== 3'b100) begin
      failed++;
      $display("[TB] FAIL sum_status: got %b required 100", {done, error, core_hold});
    end
    tests++;
    if (wrLog.size() != 7) begin
      failed++;
      $display("[TB] FAIL sum_count: got %0d required 7", wrLog.size());
    end
    for (int i = 0; i < 7 && i < wrLog.size(); i++) begin
      tests++;
      if (wrLog[i].addr !== 8'(i) || wrLog[i].data !== w[i]) begin
        failed++;
        $display("[TB] FAIL sum_word%0d: got %0h:%0h required %0h:%0h",
                 i, wrLog[i].addr, wrLog[i].data, i, w[i]);
      end
    end
    tests++;
    if (weWhileReady != 0) begin
      failed++;
      $display("[TB] FAIL we_with_ready: got %0d cycles required 0", weWhileReady);
    end
  endtask

  task automatic test_reset_midload;
    logic [31:0] w[$];
    wrLog.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({core_hold, rx_ready, mem_we, busy, done, error} !== 6'b100000 ||
        {mem_addr, mem_wdata} !== 40'd0) begin
      failed++;
      $display("[TB] FAIL midreset_values: got %b addr %0h data %0h required 100000 0 0",
               {core_hold, rx_ready, mem_we, busy, done, error}, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (wrLog.size() != 0) begin
      failed++;
      $display("[TB] FAIL midreset_writes: got %0d required 0", wrLog.size());
    end
    w = {32'h12345678};
    pulse_start();
    send_frame(w, 16'd1, 1'b0, 0, 0, -1);
    tests++;
    if (done !== 1'b1 || wrLog.size() != 1 || wrLog[0].data !== 32'h12345678) begin
      failed++;
      $display("[TB] FAIL midreset_reload: got done %b writes %0d required 1 1", done, wrLog.size());
    end
  endtask

  task automatic test_random;
    logic [31:0] w[$];
    int n;
    bit bad;
    for (int it = 0; it < 5; it++) begin
      n   = $urandom_range(8, 1);
      bad = (it % 3 == 2);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      wrLog.delete();
      pulse_start();
      send_frame(w, 16'(n), bad, 0, 2, -1);
      tests++;
      if ({done, error, core_hold} !== (bad ? 3'b011 : 3'b100)) begin
        failed++;
        $display("[TB] FAIL rand%0d_status: got %b required %b", it,
                 {done, error, core_hold}, bad ? 3'b011 : 3'b100);
      end
      tests++;
      if (wrLog.size() != n) begin
        failed++;
        $display("[TB] FAIL rand%0d_count: got %0d required %0d", it, wrLog.size(), n);
      end
      for (int i = 0; i < n && i < wrLog.size(); i++) begin
        tests++;
        if (wrLog[i].addr !== 8'(i) || wrLog[i].data !== w[i]) begin
          failed++;
          $display("[TB] FAIL rand%0d_word%0d: got %0h:%0h required %0h:%0h",
                   it, i, wrLog[i].addr, wrLog[i].data, i, w[i]);
        end
      end
    end
  endtask

  task automatic test_max_length;
    logic [31:0] w[$];
    int c0;
    int bad;
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    wrLog.delete();
    pulse_start();
    c0 = cycle;
    send_frame(w, 16'd256, 1'b0, 0, 0, -1);
    tests++;
    if ({done, error} !== 2'b10 || cycle - c0 != 3 + 5 * 256) begin
      failed++;
      $display("[TB] FAIL maxlen_status: got done/err %b in %0d cycles required 10 in %0d",
               {done, error}, cycle - c0, 3 + 5 * 256);
    end
    bad = 0;
    for (int i = 0; i < wrLog.size(); i++)
      if (wrLog[i].addr !== 8'(i) || wrLog[i].data !== w[i]) bad++;
    tests++;
    if (wrLog.size() != 256 || bad != 0) begin
      failed++;
      $display("[TB] FAIL maxlen_writes: got %0d writes %0d wrong required 256 writes 0 wrong",
               wrLog.size(), bad);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_bad_length();
    test_sum_program();
    test_reset_midload();
    test_random();
    test_max_length();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
